// File: rtl/mul8_sequencer_if.sv
// Operand, result and 4x4-multiplier signals of the sequential 8x8 multiplier.
// The slave modport is the sequencer itself; the master modport is its
// surroundings (operand source, result sink and the external 4x4 multiplier).
interface mul8_sequencer_if;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  mul_m;
  logic [3:0]  mul_q;
  logic [7:0]  mul_p;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        busy;

  modport slave (
    input  start_valid, a, b, mul_p, res_ready,
    output start_ready, mul_m, mul_q, res_valid, result, busy
  );

  modport master (
    output start_valid, a, b, mul_p, res_ready,
    input  start_ready, mul_m, mul_q, res_valid, result, busy
  );
endinterface

// File: rtl/mul8_sequencer.sv
// Sequential 8x8 unsigned multiplier. One external 4x4 multiplier is
// time-shared over four cycles: one nibble pair per cycle, each 8-bit partial
// product shifted into place and accumulated into a 16-bit sum.
module mul8_sequencer (
  input  logic             clk,
  input  logic             rst,
  mul8_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P0   = 3'd1,
    S_P1   = 3'd2,
    S_P2   = 3'd3,
    S_P3   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_ra;
  logic [7:0]  r_rb;
  logic [15:0] r_acc;
  logic [15:0] r_result;
  logic [15:0] w_addend;
  logic [15:0] w_sum;
  logic [3:0]  w_m;
  logic [3:0]  w_q;
  logic        w_accept;
  logic        w_phase;
  logic        w_load;

  // Ready only in IDLE and never while reset is held, so no accept can
  // coincide with a reset edge.
  assign bus.start_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept        = bus.start_valid & bus.start_ready;
  assign w_sum           = r_acc + w_addend;

  // Next-state decode plus the nibble pair and partial-product alignment for
  // the current phase; mul_p is only looked at in P0..P3.
  always_comb begin
    w_state_nxt = r_state;
    w_m         = 4'd0;
    w_q         = 4'd0;
    w_addend    = 16'd0;
    w_phase     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_P0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_P0: begin
        w_m         = r_ra[3:0];
        w_q         = r_rb[3:0];
        w_addend    = {8'd0, bus.mul_p};
        w_phase     = 1'b1;
        w_state_nxt = S_P1;
      end
      S_P1: begin
        w_m         = r_ra[7:4];
        w_q         = r_rb[3:0];
        w_addend    = {4'd0, bus.mul_p, 4'd0};
        w_phase     = 1'b1;
        w_state_nxt = S_P2;
      end
      S_P2: begin
        w_m         = r_ra[3:0];
        w_q         = r_rb[7:4];
        w_addend    = {4'd0, bus.mul_p, 4'd0};
        w_phase     = 1'b1;
        w_state_nxt = S_P3;
      end
      S_P3: begin
        w_m         = r_ra[7:4];
        w_q         = r_rb[7:4];
        w_addend    = {bus.mul_p, 8'd0};
        w_phase     = 1'b1;
        w_load      = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.res_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, operand latches, accumulator and held result; reset wins over
  // every handshake and aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ra     <= 8'd0;
      r_rb     <= 8'd0;
      r_acc    <= 16'd0;
      r_result <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_ra  <= bus.a;
        r_rb  <= bus.b;
        r_acc <= 16'd0;
      end else if (w_phase) begin
        r_acc <= w_sum;
      end
      if (w_load) begin
        r_result <= w_sum;
      end
    end
  end

  assign bus.mul_m     = w_m;
  assign bus.mul_q     = w_q;
  assign bus.res_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.result    = r_result;

endmodule
